// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes, opcode/funct values and the issue-stage types.
// Single source for the ALU, ALU control and the issue stage.
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_SLT  = 5'd4;
  localparam logic [4:0] ALU_SLTU = 5'd5;
  localparam logic [4:0] ALU_SLL  = 5'd6;
  localparam logic [4:0] ALU_LUI  = 5'd7;
  localparam logic [4:0] ALU_ORI  = 5'd8;
  localparam logic [4:0] ALU_BEQ  = 5'd9;
  localparam logic [4:0] ALU_BNE  = 5'd10;
  localparam logic [4:0] ALU_SLLV = 5'd11;
  localparam logic [4:0] ALU_LW   = 5'd12;
  localparam logic [4:0] ALU_SW   = 5'd13;
  localparam logic [4:0] ALU_MUL  = 5'd14;
  localparam logic [4:0] ALU_BLE  = 5'd15;
  localparam logic [4:0] ALU_BLT  = 5'd16;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLE   = 6'h06;
  localparam logic [5:0] OP_BLT   = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_MUL  = 6'h18;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic [4:0] ctrl;
    logic       imm_zext;
    logic       use_imm;
    logic       is_mul;
    logic       is_shift;
    logic       illegal;
  } dec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_MULW
  } issue_state_t;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic zext);
    return zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_op_issue_if.sv
// ID->EX issue bundle: ID-side handshake and operands, hazard controls, ALU operand/control outputs.
// The issue stage is the slave; the ID/hazard/EX environment is the master.
interface alu_op_issue_if;

  logic        id_valid_i;
  logic        id_ready_o;
  logic [5:0]  id_op_i;
  logic [5:0]  id_funct_i;
  logic [4:0]  id_shamt_i;
  logic [15:0] id_imm_i;
  logic [31:0] id_rs_data_i;
  logic [31:0] id_rt_data_i;
  logic        flush_i;
  logic        ex_stall_i;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [4:0]  alu_ctrl_o;
  logic [4:0]  alu_shamt_o;
  logic        ex_valid_o;
  logic        ex_done_o;
  logic        illegal_o;

  modport master (
    output id_valid_i, id_op_i, id_funct_i, id_shamt_i, id_imm_i,
           id_rs_data_i, id_rt_data_i, flush_i, ex_stall_i,
    input  id_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shamt_o,
           ex_valid_o, ex_done_o, illegal_o
  );

  modport slave (
    input  id_valid_i, id_op_i, id_funct_i, id_shamt_i, id_imm_i,
           id_rs_data_i, id_rt_data_i, flush_i, ex_stall_i,
    output id_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shamt_o,
           ex_valid_o, ex_done_o, illegal_o
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decoder producing the ALU control code and operand-select flags.
// Anything not listed decodes as illegal with an all-zero (add) control.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  dec.ctrl = ALU_ADD;
          FN_SUB:  dec.ctrl = ALU_SUB;
          FN_AND:  dec.ctrl = ALU_AND;
          FN_OR:   dec.ctrl = ALU_OR;
          FN_SLT:  dec.ctrl = ALU_SLT;
          FN_SLTU: dec.ctrl = ALU_SLTU;
          FN_SLL: begin
            dec.ctrl     = ALU_SLL;
            dec.is_shift = 1'b1;
          end
          FN_SLLV: begin
            dec.ctrl     = ALU_SLLV;
            dec.is_shift = 1'b1;
          end
          FN_MUL: begin
            dec.ctrl   = ALU_MUL;
            dec.is_mul = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        dec.ctrl    = ALU_ADD;
        dec.use_imm = 1'b1;
      end
      OP_SLTI: begin
        dec.ctrl    = ALU_SLT;
        dec.use_imm = 1'b1;
      end
      OP_SLTIU: begin
        dec.ctrl    = ALU_SLTU;
        dec.use_imm = 1'b1;
      end
      OP_LUI: begin
        dec.ctrl     = ALU_LUI;
        dec.use_imm  = 1'b1;
        dec.imm_zext = 1'b1;
      end
      OP_ORI: begin
        dec.ctrl     = ALU_ORI;
        dec.use_imm  = 1'b1;
        dec.imm_zext = 1'b1;
      end
      OP_LW: begin
        dec.ctrl    = ALU_LW;
        dec.use_imm = 1'b1;
      end
      OP_SW: begin
        dec.ctrl    = ALU_SW;
        dec.use_imm = 1'b1;
      end
      // Branches compare rs against rt, so they keep the register operand.
      OP_BEQ:  dec.ctrl = ALU_BEQ;
      OP_BNE:  dec.ctrl = ALU_BNE;
      OP_BLE:  dec.ctrl = ALU_BLE;
      OP_BLT:  dec.ctrl = ALU_BLT;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// ID->EX issue stage: decodes, selects operands and holds the op in EX under valid/ready,
// keeping MUL resident for MUL_CYCLES unstalled cycles; flush beats stall beats load.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic          clk_i,
  input  logic          rst_n,
  alu_op_issue_if.slave bus
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  issue_state_t state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  src1_q, src1_d;
  logic [31:0]  src2_q, src2_d;
  logic [4:0]   ctrl_q, ctrl_d;
  logic [4:0]   shamt_q, shamt_d;
  logic         illegal_q, illegal_d;
  logic         retire;
  logic         ready;
  logic         accept;
  dec_t         dec;

  alu_op_decode u_decode (
    .op    (bus.id_op_i),
    .funct (bus.id_funct_i),
    .dec   (dec)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      ctrl_q    <= ALU_ADD;
      shamt_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      ctrl_q    <= ctrl_d;
      shamt_q   <= shamt_d;
      illegal_q <= illegal_d;
    end
  end

  // A retire (or a flush) leaves a bubble behind; an accepted op in the same cycle overwrites it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    ctrl_d    = ctrl_q;
    shamt_d   = shamt_q;
    illegal_d = 1'b0;

    retire = ~bus.flush_i & ~bus.ex_stall_i &
             ((state_q == ST_HOLD) | ((state_q == ST_MULW) & (cnt_q == 4'd0)));
    ready  = ~bus.flush_i & ~bus.ex_stall_i & ((state_q == ST_IDLE) | retire);
    accept = bus.id_valid_i & ready;

    if (bus.flush_i || retire) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      src1_d  = '0;
      src2_d  = '0;
      ctrl_d  = ALU_ADD;
      shamt_d = '0;
    end else if (!bus.ex_stall_i && state_q == ST_MULW) begin
      cnt_d = cnt_q - 4'd1;
    end

    if (accept) begin
      if (dec.illegal) begin
        illegal_d = 1'b1;
      end else begin
        src1_d  = bus.id_rs_data_i;
        src2_d  = dec.use_imm ? extend_imm(bus.id_imm_i, dec.imm_zext) : bus.id_rt_data_i;
        ctrl_d  = dec.ctrl;
        shamt_d = dec.is_shift ? bus.id_shamt_i : 5'd0;
        state_d = dec.is_mul ? ST_MULW : ST_HOLD;
        cnt_d   = dec.is_mul ? MUL_LOAD : 4'd0;
      end
    end
  end

  assign bus.id_ready_o  = ready;
  assign bus.ex_done_o   = retire;
  assign bus.ex_valid_o  = (state_q != ST_IDLE);
  assign bus.illegal_o   = illegal_q;
  assign bus.alu_src1_o  = src1_q;
  assign bus.alu_src2_o  = src2_q;
  assign bus.alu_ctrl_o  = ctrl_q;
  assign bus.alu_shamt_o = shamt_q;

endmodule
